counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
- Parametrised successor to the team's fixed 16-bit enable-only up counter.
- Synchronous modulo-N up/down counter with parallel load, wrap or saturate mode, a cascade-ready terminal-count output and a registered wrap flag.
- Serves as the generic counter for timers, address generators and clock dividers in the lab designs.
- Multiple instances cascade through En/TC to build wider counters.

Parameters:
WIDTH, 16, counter width in bits; legal range 2..32.
MODULUS, 65536, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
Clk  input  1  rising-edge clock; the only clock.
Clr  input  1  asynchronous, active-low reset; 0 clears all state immediately.
En  input  1  count enable; also the cascade input from a lower stage's TC.
Up  input  1  direction: 1 = increment, 0 = decrement.
Load  input  1  synchronous parallel load.
D  input  WIDTH  load value.
Q  output  WIDTH  current count.
TC  output  1  combinational terminal count, for cascading.
Wrap  output  1  registered one-cycle pulse on every wrap event.

Behaviour:
- Reset (Clr=0, asynchronous, no clock needed):
  - Q=0, Wrap=0, and therefore TC=0.
  - Clr has priority over every other input, including in the middle of a count or load.
- Release of Clr is asynchronous; the first state change occurs at the first rising Clk edge with Clr=1.
- Per rising Clk edge with Clr=1, the priority order is:
  1. Load=1: Q<=D if D<=MODULUS-1, else Q<=MODULUS-1 (clamp). Wrap<=0. En and Up are ignored.
  2. En=1, Up=1:
     - If Q<MODULUS-1: Q<=Q+1.
     - If Q==MODULUS-1: SATURATE=0 gives Q<=0 and Wrap<=1; SATURATE=1 gives Q held and Wrap<=0.
  3. En=1, Up=0:
     - If Q>0: Q<=Q-1.
     - If Q==0: SATURATE=0 gives Q<=MODULUS-1 and Wrap<=1; SATURATE=1 gives Q held and Wrap<=0.
  4. En=0: Q held, Wrap<=0.
- Latency: Q and Wrap change one clock after the qualifying edge. Wrap is high for exactly one cycle per wrap event.
- TC = En & ((Up & Q==MODULUS-1) | (~Up & Q==0)).
  - Purely combinational, with no register stage, so cascaded stages advance on the same edge. This is the ripple-enable chain generalised to any modulus and to both directions.
  - TC is asserted in both SATURATE modes.
- Direction change: Up is sampled only at the edge; no extra cycle penalty, no glitch on Q.
- Arithmetic:
  - All comparisons and updates are unsigned, WIDTH bits.
  - Q never leaves 0..MODULUS-1 after reset or load.
  - With MODULUS=2**WIDTH, natural overflow gives the same result as explicit wrap.
- Illegal parameters (MODULUS<2 or MODULUS>2**WIDTH) are rejected at elaboration with a fatal error.

Decomposition:
- Shared counter header (include file) holds:
  - the mode constants CNT_WRAP=0 and CNT_SAT=1;
  - a MAXVAL helper macro (MODULUS-1) reused by the divider and timer blocks.
- One natural sub-module: counter_bit_cell.
  - A single flip-flop with asynchronous active-low clear and a next-state input.
  - Instantiated WIDTH times in a generate loop, replacing the hand-written per-bit instance list.
  - Next-state, boundary and TC logic stay in the top module.

Test Plan:
1. Reset: drive Clr=0 mid-count at Q=0x1234 with no clock edge -> Q=0, Wrap=0, TC=0 immediately. Release Clr, pulse En -> Q=1 one clock later.
2. Wrap up, WIDTH=4, MODULUS=10: En=1, Up=1 for 10 clocks from 0 -> Q runs 1..9 then 0. TC=1 while Q=9. Wrap=1 for exactly the cycle after Q returns to 0.
3. Wrap down, MODULUS=10: Load D=0, then En=1, Up=0 -> Q=9 next clock, Wrap=1. TC=1 while Q=0 and En=1.
4. Saturate, SATURATE=1, MODULUS=10: count up 12 clocks -> Q holds at 9, TC stays 1, Wrap never asserts. Up=0 for 12 clocks -> Q holds at 0.
5. Load priority and clamp, MODULUS=10: Load=1, En=1, D=7 -> Q=7. Next, Load=1, D=15 -> Q=9. Load=1 at Q=9 counting up -> no Wrap.
6. Cascade: two WIDTH=4, MODULUS=16 instances with the low stage's TC driving the high stage's En; run 300 clocks up from 0 -> {Qhi,Qlo}=300 mod 256=44 (0x2C). Reverse with Up=0 for 45 clocks -> 0xFF.

Source files
------------

// File: rtl/counter_updown_mod_pkg.sv
// Shared counter definitions: boundary-mode constants and the terminal-value helper
// reused by the divider and timer blocks.
package counter_updown_mod_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Highest count value reached for a given modulus.
    function automatic longint unsigned max_val(input longint unsigned modulus);
        return modulus - 64'd1;
    endfunction

endpackage

// File: rtl/counter_bit_cell.sv
// One counter bit: a flip-flop with asynchronous active-low clear and an external next-state input.
module counter_bit_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic bit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= d_i;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with parallel load, wrap/saturate boundary mode,
// combinational cascade terminal count and a registered wrap pulse.
module counter_updown_mod
    import counter_updown_mod_pkg::*;
#(
    parameter int unsigned     WIDTH    = 16,
    parameter longint unsigned MODULUS  = 65536,
    parameter int unsigned     SATURATE = CNT_WRAP
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    // Parameter legality is checked during elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "counter_updown_mod: WIDTH must be 2..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "counter_updown_mod: MODULUS must be 2..2**WIDTH");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
        $fatal(1, "counter_updown_mod: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(max_val(MODULUS));
    localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_q == MAX_Q);
    assign at_zero = (q_q == '0);

    // Next count: load beats count; boundaries either wrap (with pulse) or hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (Load) begin
            q_d = (D > MAX_Q) ? MAX_Q : D;
        end else if (En) begin
            if (Up) begin
                if (!at_max) begin
                    q_d = q_q + WIDTH'(1);
                end else if (!SAT_MODE) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - WIDTH'(1);
                end else if (!SAT_MODE) begin
                    q_d    = MAX_Q;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        counter_bit_cell u_cell (
            .clk_i  (Clk),
            .rst_ni (Clr),
            .d_i    (q_d[i]),
            .q_o    (q_q[i])
        );
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    // Unregistered so a cascaded stage advances on the same edge as this one.
    assign TC   = En & ((Up & at_max) | (~Up & at_zero));
    assign Q    = q_q;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_counter_updown_mod;

    typedef struct {
        int    due;
        int    id;
        string name;
        int    eq;
        int    ew;
        int    et;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        en0 = 0, up0 = 0, ld0 = 0;
    logic [15:0] d0  = '0;
    logic [15:0] q0;
    logic        tc0, wr0;

    logic        en1 = 0, up1 = 0, ld1 = 0;
    logic [3:0]  d1  = '0;
    logic [3:0]  q1;
    logic        tc1, wr1;

    logic        en2 = 0, up2 = 0, ld2 = 0;
    logic [3:0]  d2  = '0;
    logic [3:0]  q2;
    logic        tc2, wr2;

    logic        en3 = 0, up3 = 0, ld3 = 0;
    logic [3:0]  d3  = '0;
    logic [3:0]  qlo, qhi;
    logic        tclo, tchi, wrlo, wrhi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_updown_mod #(.WIDTH(16), .MODULUS(65536), .SATURATE(0)) u_big (
        .Clk(clk), .Clr(rst_n), .En(en0), .Up(up0), .Load(ld0), .D(d0),
        .Q(q0), .TC(tc0), .Wrap(wr0));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .Clk(clk), .Clr(rst_n), .En(en1), .Up(up1), .Load(ld1), .D(d1),
        .Q(q1), .TC(tc1), .Wrap(wr1));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .Clk(clk), .Clr(rst_n), .En(en2), .Up(up2), .Load(ld2), .D(d2),
        .Q(q2), .TC(tc2), .Wrap(wr2));

    counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_lo (
        .Clk(clk), .Clr(rst_n), .En(en3), .Up(up3), .Load(ld3), .D(d3),
        .Q(qlo), .TC(tclo), .Wrap(wrlo));

    counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_hi (
        .Clk(clk), .Clr(rst_n), .En(tclo), .Up(up3), .Load(1'b0), .D(4'd0),
        .Q(qhi), .TC(tchi), .Wrap(wrhi));

    function automatic int get_q(input int id);
        case (id)
            0:       return int'(q0);
            1:       return int'(q1);
            2:       return int'(q2);
            3:       return int'({qhi, qlo});
            default: return -2;
        endcase
    endfunction

    function automatic int get_w(input int id);
        case (id)
            0:       return int'(wr0);
            1:       return int'(wr1);
            2:       return int'(wr2);
            default: return -2;
        endcase
    endfunction

    function automatic int get_t(input int id);
        case (id)
            0:       return int'(tc0);
            1:       return int'(tc1);
            2:       return int'(tc2);
            default: return -2;
        endcase
    endfunction

    task automatic chk(input string nm, input string what, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s cyc=%0d got=%0d expected=%0d", nm, what, cyc, got, want);
        end
    endtask

    task automatic push(input int due, input int id, input string nm,
                        input int eq, input int ew, input int et);
        exp_t e;
        e.due = due; e.id = id; e.name = nm; e.eq = eq; e.ew = ew; e.et = et;
        sb.push_back(e);
    endtask

    // Drive one clock of inputs to instance id. TC is checked this cycle,
    // Q/Wrap after the coming edge; -1 skips a field.
    task automatic step(input int id, input bit en, input bit up, input bit ld, input int d,
                        input string nm, input int eq, input int ew, input int et);
        case (id)
            0: begin en0 = en; up0 = up; ld0 = ld; d0 = 16'(d); end
            1: begin en1 = en; up1 = up; ld1 = ld; d1 = 4'(d); end
            2: begin en2 = en; up2 = up; ld2 = ld; d2 = 4'(d); end
            default: begin en3 = en; up3 = up; ld3 = ld; d3 = 4'(d); end
        endcase
        if (et >= 0) push(cyc, id, nm, -1, -1, et);
        push(cyc + 1, id, nm, eq, ew, -1);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) chk(e.name, "late", e.due, cyc);
                if (e.eq >= 0) chk(e.name, "Q", get_q(e.id), e.eq);
                if (e.ew >= 0) chk(e.name, "Wrap", get_w(e.id), e.ew);
                if (e.et >= 0) chk(e.name, "TC", get_t(e.id), e.et);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        int cur;
        int nxt;
        repeat (2) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) push(cyc, id, "reset_state", 0, 0, 0);
        push(cyc, 3, "reset_casc", 0, -1, -1);
        rst_n = 1'b1;

        // Async clear in the middle of a count, with no clock edge in between.
        step(0, 0, 0, 1, 'h1234, "load_1234", 'h1234, 0, 0);
        step(0, 0, 0, 0, 0, "hold_1234", -1, -1, -1);
        en0 = 1'b1; up0 = 1'b1;
        #2;
        rst_n = 1'b0;
        push(cyc, 0, "async_clr", 0, 0, 0);
        @(posedge clk);
        #1;
        push(cyc, 0, "clr_over_en", 0, 0, 0);
        rst_n = 1'b1;
        step(0, 1, 1, 0, 0, "first_inc", 1, 0, 0);
        step(0, 0, 0, 0, 0, "hold_one", 1, 0, 0);

        // Modulo-10 wrap up.
        for (int i = 0; i < 10; i++)
            step(1, 1, 1, 0, 0, "wrap_up", (i + 1) % 10, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0);
        step(1, 0, 1, 0, 0, "wrap_pulse_end", 0, 0, 0);

        // Modulo-10 wrap down.
        step(1, 0, 0, 1, 0, "load_zero", 0, 0, 0);
        step(1, 1, 0, 0, 0, "wrap_down", 9, 1, 1);
        step(1, 1, 0, 0, 0, "down_9_8", 8, 0, 0);
        step(1, 0, 0, 0, 0, "hold_8", 8, 0, 0);

        // Saturating up then down.
        for (int i = 0; i < 12; i++) begin
            cur = (i < 9) ? i : 9;
            nxt = (i + 1 < 9) ? i + 1 : 9;
            step(2, 1, 1, 0, 0, "sat_up", nxt, 0, (cur == 9) ? 1 : 0);
        end
        for (int i = 0; i < 12; i++) begin
            cur = (9 - i > 0) ? 9 - i : 0;
            nxt = (8 - i > 0) ? 8 - i : 0;
            step(2, 1, 0, 0, 0, "sat_down", nxt, 0, (cur == 0) ? 1 : 0);
        end
        step(2, 0, 0, 0, 0, "sat_idle", 0, 0, 0);

        // Load priority and clamping.
        step(1, 1, 1, 1, 7, "load_over_en", 7, 0, 0);
        step(1, 0, 1, 1, 15, "load_clamp15", 9, 0, 0);
        step(1, 1, 1, 1, 9, "load_at_max", 9, 0, 1);
        step(1, 0, 1, 1, 10, "load_clamp10", 9, 0, 0);
        step(1, 1, 1, 0, 0, "wrap_after_ld", 0, 1, 1);
        step(1, 0, 1, 0, 0, "idle_end", 0, 0, 0);

        // Two-stage cascade through TC.
        for (int i = 0; i < 300; i++)
            step(3, 1, 1, 0, 0, "casc_up", (i + 1) % 256, -1, -1);
        for (int i = 0; i < 45; i++)
            step(3, 1, 0, 0, 0, "casc_down", (44 - (i + 1) + 256) % 256, -1, -1);
        step(3, 0, 0, 0, 0, "casc_hold", 255, -1, -1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard", "leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
